strap_pull_seq: RTL and testbench
=================================

Name: strap_pull_seq

Overview:
- Boot-time strap sampler for board-level configuration pins on the FPGA pad ring.
- Sequences the per-pad weak pull-up/pull-down controls, waits for the pads to settle under each pull, and samples them.
- Classifies each pin as tied-high, tied-low or floating.
- Sits between the pad pull primitives and the SoC config logic; after a run it parks the pulls in a low-power keeper state.

Parameters:
- NPINS, 4, number of strap pads handled.
- SETTLE_CYC, 64, clk cycles allowed for a pad to settle after a pull change (>=1).
- SYNC_STAGES, 2, flops in the per-pad input synchronizer (>=2).
- AUTO_START, 1, when 1 a run starts automatically after reset release.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- start_i, input, 1, run request; sampled only in IDLE.
- pad_i, input, NPINS, raw pad levels; asynchronous, synchronized internally.
- pull_up_o, output, NPINS, per-pad weak pull-up enable.
- pull_dn_o, output, NPINS, per-pad weak pull-down enable.
- busy_o, output, 1, run in progress.
- done_o, output, 1, one-cycle pulse when results update.
- strap_valid_o, output, 1, results valid; set by the first completed run.
- strap_high_o, output, NPINS, pin tied high.
- strap_low_o, output, NPINS, pin tied low.
- strap_float_o, output, NPINS, pin floating or conflicting.
- err_o, output, 1, at least one pin read low under pull-up and high under pull-down.

Behaviour:
- Clock and reset: single clock clk; rstn is asynchronous assert, active-low.
- Reset values:
  - pull_up_o=0, pull_dn_o=all 1.
  - busy_o=0, done_o=0, strap_valid_o=0.
  - strap_* outputs=0, err_o=0.
  - FSM=IDLE; counter=0; synchronizer flops=0.
- Synchronizer: all outputs are registered. pad_i passes through SYNC_STAGES flops before use.
- FSM states: IDLE, PU_SETTLE, PU_SAMPLE, PD_SETTLE, PD_SAMPLE, DONE.
- IDLE:
  - Leaves to PU_SETTLE when start_i=1.
  - With AUTO_START=1, also leaves on the first clk edge after rstn deasserts.
  - busy_o goes high on that same edge.
- PU_SETTLE:
  - pull_up_o=all 1, pull_dn_o=0.
  - Stays SETTLE_CYC+SYNC_STAGES cycles (counter from 0 to SETTLE_CYC+SYNC_STAGES-1), then goes to PU_SAMPLE.
- PU_SAMPLE: one cycle; captures synchronized pads into hu; pulls unchanged; then PD_SETTLE.
- PD_SETTLE: pull_up_o=0, pull_dn_o=all 1; same duration as PU_SETTLE; then PD_SAMPLE.
- PD_SAMPLE: one cycle; captures into hd; then DONE.
- DONE: one cycle; then IDLE.
  - done_o=1 and strap_valid_o=1 (sticky).
  - Per pin, hu/hd decode: hu=1,hd=1 -> high; hu=0,hd=0 -> low; hu=1,hd=0 -> float; hu=0,hd=1 -> float and err_o=1.
  - err_o is recomputed every run.
  - All strap_* outputs update atomically in this cycle.
- Parked pulls (DONE/IDLE after a run):
  - Floating pins: pull_dn_o=1, pull_up_o=0.
  - Tied pins: both 0.
- Latency: start accepted at edge t -> done_o high in cycle t+1+2*(SETTLE_CYC+SYNC_STAGES+1). With defaults that is t+135.
- Invariant: pull_up_o[i] and pull_dn_o[i] are never 1 in the same cycle.
- start_i handling:
  - Ignored while busy_o=1 and in the DONE cycle; no queuing.
  - A new start re-runs the full sequence.
  - During a re-run, strap outputs hold their previous values until the next DONE.
- busy_o=1 in every state except IDLE.
- Reset mid-run: all outputs return to reset values immediately; a partial run never produces results. With AUTO_START=1 the full sequence re-runs after release.

Test Plan:
- Reset: hold rstn=0 with random pad_i -> pull_dn_o=1111, pull_up_o=0000, busy_o=0, strap_valid_o=0, all strap_*=0, err_o=0.
- Mixed pads (defaults, AUTO_START=1): pad0=1, pad1=0, pad2 follows pull, pad3 follows inverse of pull. Required response:
  - done_o pulses exactly 135 cycles after the first post-reset edge.
  - strap_high_o=0001, strap_low_o=0010, strap_float_o=1100, err_o=1.
  - Parked pull_dn_o=1100, pull_up_o=0000.
- Busy protection: pulse start_i at cycles 10, 80 and 134 of a run -> exactly one done_o. A start 2 cycles after DONE yields a second done_o 135 cycles later, with identical results.
- Settle margin: pad follows the pull with a delay of SETTLE_CYC-1 cycles -> classified float. A delay of SETTLE_CYC+SYNC_STAGES+2 cycles makes that pad read 0 under pull-up and 1 under pull-down -> float with err_o=1.
- Reset mid PD_SETTLE -> all outputs at reset values within the asserted period, no done_o. After release, a full 135-cycle auto run completes with correct results.
- Invariant assertion over all tests: never pull_up_o[i]&pull_dn_o[i]. busy_o is low only in IDLE.

Source files
------------

// File: rtl/strap_pull_seq.sv
// Boot-time strap sampler: drives weak pull-ups then pull-downs on each strap
// pad, samples the synchronized level under each pull, classifies every pin as
// tied-high, tied-low or floating, then parks the pulls in a keeper state.
module strap_pull_seq #(
    parameter int NPINS       = 4,
    parameter int SETTLE_CYC  = 64,
    parameter int SYNC_STAGES = 2,
    parameter int AUTO_START  = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    input  logic [NPINS-1:0] pad_i,
    output logic [NPINS-1:0] pull_up_o,
    output logic [NPINS-1:0] pull_dn_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             strap_valid_o,
    output logic [NPINS-1:0] strap_high_o,
    output logic [NPINS-1:0] strap_low_o,
    output logic [NPINS-1:0] strap_float_o,
    output logic             err_o
);

    // Each pull phase covers the analog settle time plus the synchronizer depth.
    localparam int SETTLE_LEN = SETTLE_CYC + SYNC_STAGES;
    localparam int CW         = $clog2(SETTLE_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        PU_SETTLE,
        PU_SAMPLE,
        PD_SETTLE,
        PD_SAMPLE,
        DONE
    } state_t;

    state_t                              state_q, state_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic                                auto_q, auto_d;
    logic [SYNC_STAGES-1:0][NPINS-1:0]   sync_q;
    logic [NPINS-1:0]                    pad_s;
    logic [NPINS-1:0]                    hu_q, hu_d;

    logic [NPINS-1:0] pull_up_d, pull_dn_d;
    logic [NPINS-1:0] high_d, low_d, float_d;
    logic             err_d, valid_d, busy_d, done_d;

    assign pad_s = sync_q[SYNC_STAGES-1];

    // Pad input synchronizer chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Sequencer next state, sample capture, classification and next outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        auto_d    = auto_q;
        hu_d      = hu_q;
        high_d    = strap_high_o;
        low_d     = strap_low_o;
        float_d   = strap_float_o;
        err_d     = err_o;
        valid_d   = strap_valid_o;
        pull_up_d = '0;
        pull_dn_d = '1;

        case (state_q)
            IDLE: begin
                if (start_i || auto_q) begin
                    state_d = PU_SETTLE;
                    cnt_d   = '0;
                    auto_d  = 1'b0;
                end
            end
            PU_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = PU_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PU_SAMPLE: begin
                hu_d    = pad_s;
                state_d = PD_SETTLE;
            end
            PD_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = PD_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PD_SAMPLE: begin
                // The pull-down sample is decoded directly so that every
                // strap output changes together on entry to DONE.
                high_d  = hu_q & pad_s;
                low_d   = ~hu_q & ~pad_s;
                float_d = hu_q ^ pad_s;
                err_d   = |(~hu_q & pad_s);
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            PU_SETTLE, PU_SAMPLE: begin
                pull_up_d = '1;
                pull_dn_d = '0;
            end
            PD_SETTLE, PD_SAMPLE: begin
                pull_up_d = '0;
                pull_dn_d = '1;
            end
            default: begin
                // Keeper: only floating pins stay weakly pulled down.
                pull_up_d = '0;
                pull_dn_d = valid_d ? float_d : '1;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            auto_q        <= (AUTO_START != 0);
            hu_q          <= '0;
            pull_up_o     <= '0;
            pull_dn_o     <= '1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            strap_valid_o <= 1'b0;
            strap_high_o  <= '0;
            strap_low_o   <= '0;
            strap_float_o <= '0;
            err_o         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            auto_q        <= auto_d;
            hu_q          <= hu_d;
            pull_up_o     <= pull_up_d;
            pull_dn_o     <= pull_dn_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            strap_valid_o <= valid_d;
            strap_high_o  <= high_d;
            strap_low_o   <= low_d;
            strap_float_o <= float_d;
            err_o         <= err_d;
        end
    end

endmodule

// File: tb/tb_strap_pull_seq.sv
// Testbench for strap_pull_seq: pads are emulated from the pull outputs
// according to a per-pin behaviour, and results are predicted from that
// behaviour alone.
module tb_strap_pull_seq;

    localparam int NPINS = 4;
    localparam int SETTLE_CYC = 64;
    localparam int SYNC_STAGES = 2;
    localparam int RUN_LAT = 1 + 2 * (SETTLE_CYC + SYNC_STAGES + 1);

    logic             clk;
    logic             rstn;
    logic             start_i;
    logic [NPINS-1:0] pad_i;
    logic [NPINS-1:0] pull_up_o, pull_dn_o;
    logic             busy_o, done_o, strap_valid_o, err_o;
    logic [NPINS-1:0] strap_high_o, strap_low_o, strap_float_o;

    int checks = 0;
    int errors = 0;

    // Pin behaviour: 0 tied high, 1 tied low, 2 follows pull, 3 follows the
    // inverse of the pull, 4 follows pull-up with a delay of dly cycles.
    int               beh [NPINS];
    int               dly;
    logic             rand_mode;
    logic [NPINS-1:0] rand_pad;
    logic [255:0]     up_hist;

    strap_pull_seq #(
        .NPINS(NPINS),
        .SETTLE_CYC(SETTLE_CYC),
        .SYNC_STAGES(SYNC_STAGES),
        .AUTO_START(1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start_i(start_i),
        .pad_i(pad_i),
        .pull_up_o(pull_up_o),
        .pull_dn_o(pull_dn_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .strap_valid_o(strap_valid_o),
        .strap_high_o(strap_high_o),
        .strap_low_o(strap_low_o),
        .strap_float_o(strap_float_o),
        .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // History of pin-0 pull-up, used by the delayed-follow behaviour.
    initial up_hist = '0;
    always @(negedge clk) up_hist <= {up_hist[254:0], pull_up_o[0]};

    // Board model of the pads.
    always_comb begin
        pad_i = '0;
        for (int i = 0; i < NPINS; i++) begin
            case (beh[i])
                0: pad_i[i] = 1'b1;
                1: pad_i[i] = 1'b0;
                2: pad_i[i] = pull_up_o[i];
                3: pad_i[i] = ~pull_up_o[i];
                default: pad_i[i] = up_hist[dly-1];
            endcase
        end
        if (rand_mode) pad_i = rand_pad;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pull_up"}, pull_up_o, 0);
        check({tag, "_pull_dn"}, pull_dn_o, 4'hF);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_valid"}, strap_valid_o, 0);
        check({tag, "_high"}, strap_high_o, 0);
        check({tag, "_low"}, strap_low_o, 0);
        check({tag, "_float"}, strap_float_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    // Expected classification from the behaviour of each pin.
    task automatic check_straps(input string tag);
        logic [NPINS-1:0] hi, lo, fl;
        logic             er;
        hi = '0; lo = '0; fl = '0; er = 1'b0;
        for (int i = 0; i < NPINS; i++) begin
            case (beh[i])
                0: hi[i] = 1'b1;
                1: lo[i] = 1'b1;
                2: fl[i] = 1'b1;
                3: begin fl[i] = 1'b1; er = 1'b1; end
                default: begin
                    fl[i] = 1'b1;
                    if (dly > SETTLE_CYC + SYNC_STAGES - 1) er = 1'b1;
                end
            endcase
        end
        check({tag, "_valid"}, strap_valid_o, 1);
        check({tag, "_high"}, strap_high_o, hi);
        check({tag, "_low"}, strap_low_o, lo);
        check({tag, "_float"}, strap_float_o, fl);
        check({tag, "_err"}, err_o, er);
    endtask

    task automatic check_park(input string tag);
        logic [NPINS-1:0] fl;
        fl = '0;
        for (int i = 0; i < NPINS; i++) fl[i] = (beh[i] >= 2);
        check({tag, "_park_up"}, pull_up_o, 0);
        check({tag, "_park_dn"}, pull_dn_o, fl);
    endtask

    // Counts cycles after the accepting edge until done_o is seen; n=1 is the
    // first cycle after that edge. Gives up after 400 cycles.
    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            n++;
            if (done_o === 1'b1) break;
        end
    endtask

    task automatic randomize_beh();
        for (int i = 0; i < NPINS; i++) beh[i] = int'($urandom_range(3, 0));
    endtask

    // Safety invariants checked every cycle outside reset.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            assert ((pull_up_o & pull_dn_o) === '0) else begin
                errors++;
                $error("FAIL pull_overlap observed up=%b dn=%b expected=disjoint", pull_up_o, pull_dn_o);
            end
            checks++;
            assert (busy_o === 1'b1 || pull_up_o === '0) else begin
                errors++;
                $error("FAIL idle_pull_up observed=%b expected=0 while not busy", pull_up_o);
            end
            if (done_o === 1'b1) begin
                checks++;
                assert (busy_o === 1'b1) else begin
                    errors++;
                    $error("FAIL busy_in_done observed=%b expected=1", busy_o);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt, first, second;

        rstn = 1'b0;
        start_i = 1'b0;
        rand_mode = 1'b1;
        rand_pad = '0;
        beh = '{0, 1, 2, 3};
        dly = 1;

        // Reset with random pads.
        repeat (6) begin
            @(negedge clk);
            rand_pad = NPINS'($urandom);
        end
        check_reset("reset");
        rand_mode = 1'b0;

        // Automatic run after release with the mixed pad set.
        @(negedge clk);
        rstn = 1'b1;
        wait_done(n);
        check("auto_latency", n, RUN_LAT);
        check("mixed_high", strap_high_o, 4'b0001);
        check("mixed_low", strap_low_o, 4'b0010);
        check("mixed_float", strap_float_o, 4'b1100);
        check("mixed_err", err_o, 1);
        check("mixed_park_dn", pull_dn_o, 4'b1100);
        check("mixed_park_up", pull_up_o, 4'b0000);
        @(negedge clk);
        check("mixed_done_pulse", done_o, 0);
        check("mixed_idle_busy", busy_o, 0);

        // Randomized runs triggered by start_i.
        repeat (6) begin
            randomize_beh();
            repeat ($urandom_range(6, 1)) @(negedge clk);
            start_i = 1'b1;
            wait_done(n);
            check("rand_latency", n, RUN_LAT);
            check_straps("rand");
            check_park("rand");
            @(negedge clk);
            check("rand_done_pulse", done_o, 0);
            check("rand_idle_busy", busy_o, 0);
        end

        // Starts during a run are ignored; a start after DONE re-runs.
        randomize_beh();
        repeat (3) @(negedge clk);
        start_i = 1'b1;
        cnt = 0; first = 0; second = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                cnt++;
                if (cnt == 1) first = k;
                if (cnt == 2) second = k;
                check_straps("busy_run");
            end
            if (k == 200) check_straps("rerun_hold");
            start_i = (k == 10 || k == 80 || k == 134 || k == 137);
        end
        start_i = 1'b0;
        check("busy_done_count", cnt, 2);
        check("busy_first_done", first, RUN_LAT);
        check("busy_second_done", second, 137 + RUN_LAT);

        // Pad that follows the pull within the settle window.
        for (int i = 1; i < NPINS; i++) beh[i] = int'($urandom_range(3, 0));
        beh[0] = 4;
        dly = SETTLE_CYC - 1;
        repeat (100) @(negedge clk);
        start_i = 1'b1;
        wait_done(n);
        check("margin_in_latency", n, RUN_LAT);
        check("margin_in_float0", strap_float_o[0], 1);
        check_straps("margin_in");
        check_park("margin_in");

        // Pad too slow to follow the pull: reads the opposite level.
        dly = SETTLE_CYC + SYNC_STAGES + 2;
        repeat (100) @(negedge clk);
        start_i = 1'b1;
        wait_done(n);
        check("margin_out_latency", n, RUN_LAT);
        check("margin_out_float0", strap_float_o[0], 1);
        check("margin_out_err", err_o, 1);
        check_straps("margin_out");

        // Reset while in the pull-down settle phase.
        randomize_beh();
        repeat (4) @(negedge clk);
        start_i = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rstn = 1'b0;
        #1;
        check_reset("midrun_reset");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("midrun_no_done", done_o, 0);
        end
        check_reset("midrun_held");
        rstn = 1'b1;
        wait_done(n);
        check("rerun_latency", n, RUN_LAT);
        check_straps("rerun");
        check_park("rerun");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
